phase_scheduler: RTL and testbench

Sequences green phases across the 8 approach lanes of the intersection, arbitrating round-robin among lanes with waiting vehicles. Green time scales with queue depth, and yellow and all-red clearance intervals are inserted between phases. Emergency preemption and an optional pedestrian walk phase are layered on top. It replaces the free-running day-time rotation as the source of the 8-bit light vector fed into the light-output mux.

---
 rtl/traffic_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/phase_scheduler.sv | 170 +++++++++++++++++
 tb/tb_phase_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lane count, phase time type, phase state enum and default timings
package traffic_pkg;
    localparam int NUM_LANES = 8;
    typedef logic [6:0] phase_time_t;
    typedef enum logic [2:0] {ALL_RED, GREEN, YELLOW, WALK, EMG} phase_state_t;
    localparam int DEF_MIN_GREEN   = 5;
    localparam int DEF_MAX_GREEN   = 60;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 2;
    localparam int DEF_WALK_TIME   = 15;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requesting lane after lastIdx
//   req      - per-lane request
//   lastIdx  - index of the previously granted lane
//   grant    - one-hot grant, zero when nothing requests
//   grantIdx - index of the granted lane (lastIdx when nothing requests)
module rr_arbiter
    import traffic_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [2:0]           lastIdx,
    output logic [NUM_LANES-1:0] grant,
    output logic [2:0]           grantIdx
);
    logic [2:0] idx;
    logic       found;

    always_comb begin
        grant    = '0;
        grantIdx = lastIdx;
        found    = 1'b0;
        idx      = lastIdx;
        for (int k = 1; k <= NUM_LANES; k++) begin
            idx = lastIdx + 3'(k);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx;
            end
        end
    end
endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: round-robin green/yellow/all-red sequencer with emergency preemption
//   clk, rst   - one cycle per second; async active-high reset
//   lanes      - per-lane queue counts, sampled only at the all-red decision point
//   emgSignal  - emergency present; emgLane one-hot request (lowest set bit wins)
//   pedSignal  - pedestrian request (only with PHASE_SCHEDULER_PED_EN defined)
//   green, yellow, walk, phaseTimer - registered light vector and seconds remaining
//   busy       - high whenever the scheduler is not in all-red
// Build option: PHASE_SCHEDULER_PED_EN adds the pedestrian WALK phase.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0][7:0]   lanes,
    input  logic                        emgSignal,
    input  logic [NUM_LANES-1:0]        emgLane,
    input  logic                        pedSignal,
    output logic [NUM_LANES-1:0]        green,
    output logic [NUM_LANES-1:0]        yellow,
    output logic                        walk,
    output phase_time_t                 phaseTimer,
    output logic                        busy
);
    localparam phase_time_t YELLOW_T = phase_time_t'(YELLOW_TIME - 1);
    localparam phase_time_t ALLRED_T = phase_time_t'(ALLRED_TIME - 1);

    phase_state_t         state, stateNext;
    phase_time_t          timerNext, greenLen;
    logic [NUM_LANES-1:0] greenNext, yellowNext, req, grant, emgPick;
    logic [2:0]           lastLane, lastLaneNext, grantIdx;
    logic [8:0]           greenSum;
    logic                 emgActive;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : gReq
            assign req[i] = |lanes[i];
        end
    endgenerate

    rr_arbiter uArb (
        .req      (req),
        .lastIdx  (lastLane),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    // isolate the lowest set emergency bit
    assign emgPick   = emgLane & (~emgLane + NUM_LANES'(1));
    assign emgActive = emgSignal && (emgLane != '0);
    assign greenSum  = 9'(MIN_GREEN) + {1'b0, lanes[grantIdx]};
    assign greenLen  = (greenSum > 9'(MAX_GREEN)) ? phase_time_t'(MAX_GREEN) : greenSum[6:0];
    assign busy      = state != ALL_RED;

`ifdef PHASE_SCHEDULER_PED_EN
    localparam phase_time_t WALK_T = phase_time_t'(WALK_TIME - 1);
    logic pedPending, pedNext, walkNext;
`else
    logic unusedPed;
    assign unusedPed = pedSignal;
    assign walk      = 1'b0;
`endif

    always_comb begin
        stateNext    = state;
        timerNext    = phaseTimer - 7'd1;
        greenNext    = green;
        yellowNext   = yellow;
        lastLaneNext = lastLane;
`ifdef PHASE_SCHEDULER_PED_EN
        walkNext     = walk;
`endif
        case (state)
            ALL_RED: if (phaseTimer == '0) begin
                timerNext = '0;
                if (emgActive) begin
                    stateNext = EMG;
                    greenNext = emgPick;
                end
`ifdef PHASE_SCHEDULER_PED_EN
                else if (pedPending) begin
                    stateNext = WALK;
                    walkNext  = 1'b1;
                    timerNext = WALK_T;
                end
`endif
                else if (|req) begin
                    stateNext    = GREEN;
                    greenNext    = grant;
                    timerNext    = greenLen - 7'd1;
                    lastLaneNext = grantIdx;
                end
            end
            GREEN: if (emgActive && emgPick == green) begin
                stateNext = EMG;
                timerNext = '0;
            end else if (emgActive || phaseTimer == '0) begin
                stateNext  = YELLOW;
                greenNext  = '0;
                yellowNext = green;
                timerNext  = YELLOW_T;
            end
            YELLOW: if (phaseTimer == '0) begin
                stateNext  = ALL_RED;
                yellowNext = '0;
                timerNext  = ALLRED_T;
            end
`ifdef PHASE_SCHEDULER_PED_EN
            WALK: if (emgActive || phaseTimer == '0) begin
                stateNext = ALL_RED;
                walkNext  = 1'b0;
                timerNext = ALLRED_T;
            end
`endif
            EMG: begin
                timerNext = '0;
                if (!emgActive || emgPick != green) begin
                    stateNext  = YELLOW;
                    greenNext  = '0;
                    yellowNext = green;
                    timerNext  = YELLOW_T;
                end
            end
            default: begin
                stateNext  = ALL_RED;
                greenNext  = '0;
                yellowNext = '0;
                timerNext  = ALLRED_T;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ALL_RED;
            phaseTimer <= ALLRED_T;
            green      <= '0;
            yellow     <= '0;
            lastLane   <= 3'd7;
        end else begin
            state      <= stateNext;
            phaseTimer <= timerNext;
            green      <= greenNext;
            yellow     <= yellowNext;
            lastLane   <= lastLaneNext;
        end
    end

`ifdef PHASE_SCHEDULER_PED_EN
    // requests arriving during WALK are dropped; pending clears on WALK entry
    assign pedNext = (stateNext == WALK && state != WALK) ? 1'b0 :
                     (state == WALK) ? pedPending : (pedPending | pedSignal);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk       <= 1'b0;
            pedPending <= 1'b0;
        end else begin
            walk       <= walkNext;
            pedPending <= pedNext;
        end
    end
`endif
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: directed scenario tasks plus a randomized run against a phase-list model
module tb_phase_scheduler;
    localparam int MIN_G = 5, MAX_G = 60, YEL = 3, AR = 2, WLK = 15;

    logic             clk = 1'b0, rst = 1'b0;
    logic [7:0][7:0]  lanes = '0;
    logic             emgSignal = 1'b0, pedSignal = 1'b0;
    logic [7:0]       emgLane = '0;
    logic [7:0]       green, yellow;
    logic             walk, busy;
    logic [6:0]       phaseTimer;
    int               errors = 0, checks = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] y;
        logic       w;
        logic [6:0] t;
        logic       b;
    } exp_t;
    exp_t plan[$];
    int   mLast;

    phase_scheduler dut (
        .clk(clk), .rst(rst), .lanes(lanes), .emgSignal(emgSignal), .emgLane(emgLane),
        .pedSignal(pedSignal), .green(green), .yellow(yellow), .walk(walk),
        .phaseTimer(phaseTimer), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        emgSignal = 1'b0;
        emgLane = '0;
        pedSignal = 1'b0;
        lanes = '0;
        step();
        rst = 1'b0;
    endtask

    // count consecutive cycles showing the given light pattern (bounded)
    task automatic runLen(input logic [7:0] g, input logic [7:0] y, input logic w, output int n);
        n = 0;
        while (green === g && yellow === y && walk === w && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        lanes = 8'hFF;
        rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, walk, phaseTimer, busy} !== {8'h00, 8'h00, 1'b0, 7'd1, 1'b0}) begin
            errors++;
            $display("FAIL reset: g=%h y=%h w=%b t=%0d b=%b want 00 00 0 1 0", green, yellow, walk, phaseTimer, busy);
        end
        step();
        rst = 1'b0;
        lanes = '0;
    endtask

    task automatic test_idle();
        logic bad = 1'b0;
        doReset();
        for (int c = 0; c < 20; c++) begin
            step();
            if (busy !== 1'b0 || green !== 8'h00 || phaseTimer !== 7'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle: busy=%b green=%h t=%0d want idle all-red", busy, green, phaseTimer);
        end
    endtask

    task automatic test_single_lane();
        int n;
        doReset();
        lanes[2] = 8'd3;
        step();
        step();
        checks++;
        if (green !== 8'h04 || phaseTimer !== 7'd7) begin
            errors++;
            $display("FAIL single_first: green=%h t=%0d want 04 7", green, phaseTimer);
        end
        lanes = '0;
        runLen(8'h04, 8'h00, 1'b0, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL single_green_len: got %0d want 8", n); end
        runLen(8'h00, 8'h04, 1'b0, n);
        checks++;
        if (n !== YEL) begin errors++; $display("FAIL single_yellow_len: got %0d want %0d", n, YEL); end
        checks++;
        if (phaseTimer !== 7'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_allred1: t=%0d busy=%b want 1 0", phaseTimer, busy);
        end
        step();
        step();
        checks++;
        if (phaseTimer !== 7'd0 || green !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after: t=%0d green=%h busy=%b want 0 00 0", phaseTimer, green, busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        doReset();
        lanes[1] = 8'd100;
        lanes[5] = 8'd100;
        step();
        step();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] g;
            g = (r == 0) ? 8'h02 : 8'h20;
            runLen(g, 8'h00, 1'b0, n);
            checks++;
            if (n !== MAX_G) begin errors++; $display("FAIL rr_green%0d: got %0d want %0d", r, n, MAX_G); end
            runLen(8'h00, g, 1'b0, n);
            checks++;
            if (n !== YEL) begin errors++; $display("FAIL rr_yellow%0d: got %0d want %0d", r, n, YEL); end
            runLen(8'h00, 8'h00, 1'b0, n);
            checks++;
            if (n !== AR) begin errors++; $display("FAIL rr_allred%0d: got %0d want %0d", r, n, AR); end
        end
        checks++;
        if (green !== 8'h02) begin errors++; $display("FAIL rr_wrap: green=%h want 02", green); end
    endtask

    task automatic test_emergency();
        int  n;
        logic bad = 1'b0;
        doReset();
        lanes[0] = 8'd10;
        step();
        step();
        checks++;
        if (green !== 8'h01) begin errors++; $display("FAIL emg_pre: green=%h want 01", green); end
        step();
        step();
        step();
        emgSignal = 1'b1;
        emgLane = 8'h80;
        step();
        checks++;
        if (yellow !== 8'h01 || green !== 8'h00 || phaseTimer !== 7'd2) begin
            errors++;
            $display("FAIL emg_truncate: y=%h g=%h t=%0d want 01 00 2", yellow, green, phaseTimer);
        end
        runLen(8'h00, 8'h01, 1'b0, n);
        checks++;
        if (n !== YEL) begin errors++; $display("FAIL emg_yellow_len: got %0d want %0d", n, YEL); end
        runLen(8'h00, 8'h00, 1'b0, n);
        checks++;
        if (n !== AR) begin errors++; $display("FAIL emg_allred_len: got %0d want %0d", n, AR); end
        for (int c = 0; c < 10; c++) begin
            if (green !== 8'h80 || phaseTimer !== 7'd0 || busy !== 1'b1) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL emg_hold: green=%h t=%0d want 80 0", green, phaseTimer); end
        emgSignal = 1'b0;
        step();
        checks++;
        if (yellow !== 8'h80 || green !== 8'h00) begin
            errors++;
            $display("FAIL emg_release: y=%h g=%h want 80 00", yellow, green);
        end
    endtask

    task automatic test_emg_same_lane();
        logic bad = 1'b0;
        doReset();
        lanes[4] = 8'd20;
        step();
        step();
        emgSignal = 1'b1;
        emgLane = 8'h10;
        for (int c = 0; c < 6; c++) begin
            step();
            if (green !== 8'h10 || yellow !== 8'h00 || phaseTimer !== 7'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL emg_same: g=%h y=%h t=%0d want 10 00 0", green, yellow, phaseTimer); end
        emgLane = 8'h18;
        step();
        checks++;
        if (yellow !== 8'h10 || green !== 8'h00) begin
            errors++;
            $display("FAIL emg_lane_change: y=%h g=%h want 10 00", yellow, green);
        end
        emgSignal = 1'b0;
        emgLane = '0;
    endtask

`ifdef PHASE_SCHEDULER_PED_EN
    task automatic test_ped();
        int  n;
        logic bad = 1'b0;
        doReset();
        lanes[3] = 8'd2;
        step();
        step();
        checks++;
        if (green !== 8'h08) begin errors++; $display("FAIL ped_green: green=%h want 08", green); end
        pedSignal = 1'b1;
        step();
        pedSignal = 1'b0;
        lanes = '0;
        runLen(8'h08, 8'h00, 1'b0, n);
        runLen(8'h00, 8'h08, 1'b0, n);
        checks++;
        if (n !== YEL) begin errors++; $display("FAIL ped_yellow_len: got %0d want %0d", n, YEL); end
        runLen(8'h00, 8'h00, 1'b0, n);
        checks++;
        if (n !== AR) begin errors++; $display("FAIL ped_allred_len: got %0d want %0d", n, AR); end
        n = 0;
        while (walk === 1'b1 && n < 300) begin
            if (busy !== 1'b1) bad = 1'b1;
            pedSignal = (n == 3);
            step();
            n++;
        end
        pedSignal = 1'b0;
        checks++;
        if (n !== WLK || bad) begin errors++; $display("FAIL ped_walk_len: got %0d busy_bad=%b want %0d", n, bad, WLK); end
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (walk !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ped_no_extra: walk=%b want 0", walk); end
    endtask
`else
    task automatic test_ped();
        logic bad = 1'b0;
        doReset();
        pedSignal = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 3) pedSignal = 1'b0;
            step();
            if (walk !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL ped_disabled: walk=%b busy=%b want 0 0", walk, busy); end
    endtask
`endif

    task automatic test_rst_mid_yellow();
        int n = 0;
        doReset();
        lanes[2] = 8'd3;
        while (yellow === 8'h00 && n < 100) begin
            step();
            n++;
        end
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, walk, phaseTimer, busy} !== {8'h00, 8'h00, 1'b0, 7'd1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_yellow: g=%h y=%h w=%b t=%0d b=%b want 00 00 0 1 0 (waited %0d)",
                     green, yellow, walk, phaseTimer, busy, n);
        end
        step();
        rst = 1'b0;
        lanes = '0;
    endtask

    task automatic push(input logic [7:0] g, input logic [7:0] y, input int t, input logic b);
        exp_t e;
        e.g = g;
        e.y = y;
        e.w = 1'b0;
        e.t = 7'(t);
        e.b = b;
        plan.push_back(e);
    endtask

    // next phase list chosen at a decision point from the currently driven counts
    task automatic expand();
        int idx = -1, len;
        for (int k = 1; k <= 8; k++)
            if (idx < 0 && lanes[(mLast + k) % 8] != 8'd0) idx = (mLast + k) % 8;
        if (idx < 0) begin
            push(8'h00, 8'h00, 0, 1'b0);
        end else begin
            logic [7:0] oh;
            oh = 8'h01 << idx;
            mLast = idx;
            len = MIN_G + int'(lanes[idx]);
            if (len > MAX_G) len = MAX_G;
            for (int t = len - 1; t >= 0; t--) push(oh, 8'h00, t, 1'b1);
            for (int t = YEL - 1; t >= 0; t--) push(8'h00, oh, t, 1'b1);
            for (int t = AR - 1; t >= 0; t--) push(8'h00, 8'h00, t, 1'b0);
        end
    endtask

    task automatic test_random();
        exp_t e, o;
        doReset();
        plan.delete();
        mLast = 7;
        push(8'h00, 8'h00, 1, 1'b0);
        push(8'h00, 8'h00, 0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            e = plan.pop_front();
            o = {green, yellow, walk, phaseTimer, busy};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random cycle %0d: g=%h y=%h w=%b t=%0d b=%b want g=%h y=%h w=%b t=%0d b=%b",
                         c, o.g, o.y, o.w, o.t, o.b, e.g, e.y, e.w, e.t, e.b);
            end
            for (int i = 0; i < 8; i++)
                lanes[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 120)) : 8'd0;
            if (plan.size() == 0) expand();
            step();
        end
        lanes = '0;
    endtask

    initial begin
        step();
        test_reset();
        test_idle();
        test_single_lane();
        test_round_robin();
        test_emergency();
        test_emg_same_lane();
        test_ped();
        test_rst_mid_yellow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
